// File: rtl/mdu_iter_if.sv
// Request/response bundle between the datapath and the iterative multiply/divide unit.
// The datapath drives the request side; the unit returns status and the HI/LO registers.
interface mdu_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// It handles one bit per cycle (shift-add multiply, restoring divide) and then applies a sign fix-up.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic       clk,
    input logic       reset,
    mdu_iter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               done_q, done_d;

    logic               signed_op;
    logic               sign_xor;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign signed_op = bus.op[0];
    assign sign_xor  = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
    assign abs_a     = (signed_op && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign abs_b     = (signed_op && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: acc holds {partial remainder, remaining dividend / growing quotient}.
    assign shl   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial = shl - {1'b0, opnd_q};

    assign prod_fix = res_neg_q ? -acc_q : acc_q;
    assign quo_fix  = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (bus.op)
                        3'b000, 3'b001: begin
                            acc_d     = {{WIDTH{1'b0}}, abs_b};
                            opnd_d    = abs_a;
                            is_div_d  = 1'b0;
                            res_neg_d = signed_op & sign_xor;
                            rem_neg_d = 1'b0;
                            cnt_d     = '0;
                            state_d   = StRun;
                        end
                        3'b010, 3'b011: begin
                            acc_d     = {{WIDTH{1'b0}}, abs_a};
                            opnd_d    = abs_b;
                            is_div_d  = 1'b1;
                            res_neg_d = signed_op & sign_xor;
                            rem_neg_d = signed_op & bus.A[WIDTH-1];
                            cnt_d     = '0;
                            state_d   = StRun;
                        end
                        3'b100:  hi_d = bus.A;
                        3'b101:  lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (is_div_q) begin
                    // No borrow out of the trial subtraction means the divisor fits.
                    if (!trial[WIDTH]) begin
                        acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {add_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (opnd_q != '0) begin
                    // A zero divisor leaves HI/LO untouched but still completes.
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter.
// Expected HI/LO values are queued at issue time and compared whenever done pulses.
module tb_mdu_iter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(W)) bus ();

    mdu_iter #(
        .WIDTH(W),
        .CNT_W(5)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] hi_m, lo_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference {hi, lo}; cur is returned when the divisor is zero.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        logic [63:0] p;
        int          sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'b000: p = {32'd0, a} * {32'd0, b};
            3'b001: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            3'b010: p = (b == 0) ? cur : {a % b, a / b};
            3'b011: begin
                if (b == 0) p = cur;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
                else p = {32'(sa % sb), 32'(sa / sb)};
            end
            default: p = cur;
        endcase
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            if (exp_q.size() == 0) check("spurious_done", 64'(bus.done), 64'd0);
            else check("result", {bus.hi, bus.lo}, exp_q.pop_front());
        end
    end

    // Called just after a negedge. When intrude > 0, a MULTU start is pulsed at that busy cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int intrude, input bit chain);
        logic [63:0] e;
        int          cnt;
        e = model(op, a, b, {hi_m, lo_m});
        exp_q.push_back(e);
        {hi_m, lo_m} = e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        cnt = 0;
        while (bus.busy && cnt < 60) begin
            cnt++;
            bus.start = (cnt == intrude);
            bus.op    = 3'b000;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("busy_len", 64'(cnt), 64'd33);
        check("done_rise", 64'(bus.done), 64'd1);
        if (!chain) begin
            @(negedge clk);
            check("done_fall", 64'(bus.done), 64'd0);
        end
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        @(negedge clk);
        bus.start = 1'b0;
        if (op == 3'b100) hi_m = a;
        else lo_m = a;
        check("mt_busy", 64'(bus.busy), 64'd0);
        check("mt_done", 64'(bus.done), 64'd0);
        check("mt_hilo", {bus.hi, bus.lo}, {hi_m, lo_m});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int d0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.A     = '0;
        bus.B     = '0;
        hi_m      = '0;
        lo_m      = '0;
        repeat (2) @(negedge clk);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        mt(3'b100, 32'h1234_5678);
        mt(3'b101, 32'h9ABC_DEF0);
        check("mt_const", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);

        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        check("multu_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'b001, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
        check("mult_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        check("div_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        check("div_ovf_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        mt(3'b100, 32'h1111_1111);
        mt(3'b101, 32'h2222_2222);
        run_op(3'b010, 32'd12345, 32'd0, 0, 1'b0);
        check("div0_const", {bus.hi, bus.lo}, 64'h1111_1111_2222_2222);

        run_op(3'b010, 32'd100, 32'd7, 10, 1'b0);
        check("divu_intrude", {bus.hi, bus.lo}, {32'd2, 32'd14});

        // A start issued in the done cycle is expected to be accepted.
        run_op(3'b001, 32'd1234, 32'hFFFF_E9D2, 0, 1'b1);
        run_op(3'b011, 32'h8765_4321, 32'd77, 0, 1'b1);
        run_op(3'b010, 32'hDEAD_BEEF, 32'h0001_0003, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i % 3 == 0) rb = -rb;
            run_op(3'($urandom_range(0, 3)), ra, rb, 0, 1'b0);
        end

        // Abort a MULTU in flight: no result is queued, so any done pulse is flagged.
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.A     = 32'hCAFE_F00D;
        bus.B     = 32'h0000_1234;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        d0    = n_done;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(n_done), 64'(d0));
        check("abort_idle", 64'(bus.busy), 64'd0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
